// File: rtl/dsp_slave_regs_pkg.sv
// Shared constants for dsp_slave_regs: control field positions, register word offsets,
// FSM state encoding and equation numbers driven into the equations top.
package dsp_slave_regs_pkg;

    // CTRL fields
    localparam int F_DSP_SLAVE_EQUATION_NUMBER_LSB = 0;
    localparam int F_DSP_SLAVE_EQUATION_NUMBER_MSB = 3;
    localparam int F_DSP_SLAVE_START_BIT           = 8;
    localparam int F_DSP_SLAVE_ABORT_BIT           = 9;

    // Register word offsets (byte address bits [6:2])
    localparam logic [4:0] W_CTRL          = 5'd0;
    localparam logic [4:0] W_INPUT1        = 5'd1;
    localparam logic [4:0] W_RESULT0       = 5'd5;
    localparam logic [4:0] W_STATUS        = 5'd10;
    localparam logic [4:0] W_IRQ_EN        = 5'd11;
    localparam logic [4:0] W_TIMEOUT_LIMIT = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    localparam logic [3:0] B_DSP_EQUATION_NONE = 4'd0;
    localparam logic [3:0] B_DSP_EQUATION_1    = 4'd1;
    localparam logic [3:0] B_DSP_EQUATION_2    = 4'd2;
    localparam logic [3:0] B_DSP_EQUATION_3    = 4'd3;
    localparam logic [3:0] B_DSP_EQUATION_4    = 4'd4;

endpackage

// File: rtl/dsp_slave_regs_run_timer.sv
// Run-cycle counter with limit compare; a zero limit never expires.
module dsp_run_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign expired = (limit != 32'd0) && (count_reg == limit);

endmodule

// File: rtl/dsp_slave_regs.sv
// Wishbone classic register block that launches one DSP equation and captures its results.
// Optional run timeout (TIMEOUT_LIMIT register at 0x30) is built when DSP_SLAVE_TIMEOUT_EN is defined.
module dsp_slave_regs
    import dsp_slave_regs_pkg::*;
#(
    parameter int dw = 32,
    parameter int aw = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic [dw-1:0] dsp_input0_reg,
    output logic [dw-1:0] dsp_input1_reg,
    output logic [dw-1:0] dsp_input2_reg,
    output logic [dw-1:0] dsp_input3_reg,
    output logic [dw-1:0] dsp_input4_reg,
    input  logic [dw-1:0] dsp_output0_reg,
    input  logic [dw-1:0] dsp_output1_reg,
    input  logic [dw-1:0] dsp_output2_reg,
    input  logic [dw-1:0] dsp_output3_reg,
    input  logic [dw-1:0] dsp_output4_reg,
    input  logic          done,
    output logic          interrupt
);

    state_t        state_reg;
    logic [3:0]    eqn_reg;
    logic [dw-1:0] input_reg  [4];
    logic [dw-1:0] result_reg [5];
    logic          status_done_reg;
    logic          status_timeout_reg;
    logic [1:0]    irq_en_reg;
    logic          ack_reg;
    logic [dw-1:0] dat_reg;
    logic          irq_reg;
    logic [dw-1:0] rd_data;
    logic [dw-1:0] wmask;
    logic [dw-1:0] dsp_out [5];
    logic          timeout_hit;

    logic [4:0] word;
    logic       req;
    logic       wr_commit;
    logic       busy;
    logic       start_wr;
    logic       abort_wr;
    logic       unused_adr;

    assign word       = wb_adr_i[6:2];
    assign unused_adr = ^{wb_adr_i[aw-1:7], wb_adr_i[1:0]};
    assign req        = wb_cyc_i & wb_stb_i;
    // Writes take effect at the edge that ends the ack cycle, so BUSY follows the ack.
    assign wr_commit  = req & wb_we_i & ack_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign start_wr   = wr_commit && (word == W_CTRL) && wb_sel_i[1] && wb_dat_i[F_DSP_SLAVE_START_BIT];
    assign abort_wr   = wr_commit && (word == W_CTRL) && wb_sel_i[1] && wb_dat_i[F_DSP_SLAVE_ABORT_BIT];

    for (genvar gi = 0; gi < dw / 8; gi++) begin : g_mask
        assign wmask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end

    assign dsp_out[0] = dsp_output0_reg;
    assign dsp_out[1] = dsp_output1_reg;
    assign dsp_out[2] = dsp_output2_reg;
    assign dsp_out[3] = dsp_output3_reg;
    assign dsp_out[4] = dsp_output4_reg;

    function automatic logic [dw-1:0] merge(input logic [dw-1:0] old_v, input logic [dw-1:0] new_v,
                                            input logic [dw-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

`ifdef DSP_SLAVE_TIMEOUT_EN
    logic [31:0] timeout_limit_reg;

    dsp_run_timer u_run_timer (
        .clk     (wb_clk),
        .rst_n   (wb_rst_n),
        .clear   (start_wr && (state_reg == ST_IDLE)),
        .run     (state_reg == ST_RUN),
        .limit   (timeout_limit_reg),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (word)
            W_CTRL:          rd_data[F_DSP_SLAVE_EQUATION_NUMBER_MSB:F_DSP_SLAVE_EQUATION_NUMBER_LSB] = eqn_reg;
            W_STATUS:        rd_data[2:0] = {status_timeout_reg, status_done_reg, busy};
            W_IRQ_EN:        rd_data[1:0] = irq_en_reg;
`ifdef DSP_SLAVE_TIMEOUT_EN
            W_TIMEOUT_LIMIT: rd_data = timeout_limit_reg;
`endif
            default:         rd_data = '0;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (word == W_INPUT1 + 5'(i)) rd_data = input_reg[i];
        end
        for (int i = 0; i < 5; i++) begin
            if (word == W_RESULT0 + 5'(i)) rd_data = result_reg[i];
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg          <= ST_IDLE;
            eqn_reg            <= '0;
            status_done_reg    <= 1'b0;
            status_timeout_reg <= 1'b0;
            irq_en_reg         <= '0;
            ack_reg            <= 1'b0;
            dat_reg            <= '0;
            irq_reg            <= 1'b0;
            for (int i = 0; i < 4; i++) input_reg[i] <= '0;
            for (int i = 0; i < 5; i++) result_reg[i] <= '0;
`ifdef DSP_SLAVE_TIMEOUT_EN
            timeout_limit_reg  <= '0;
`endif
        end else begin
            ack_reg <= req & ~ack_reg;
            dat_reg <= (req & ~ack_reg) ? rd_data : '0;

            if (wr_commit) begin
                if (word == W_CTRL && !busy && wb_sel_i[0]) eqn_reg <= wb_dat_i[3:0];
                for (int i = 0; i < 4; i++) begin
                    if (word == W_INPUT1 + 5'(i) && !busy)
                        input_reg[i] <= merge(input_reg[i], wb_dat_i, wmask);
                end
                if (word == W_STATUS && wb_sel_i[0]) begin
                    if (wb_dat_i[1]) status_done_reg    <= 1'b0;
                    if (wb_dat_i[2]) status_timeout_reg <= 1'b0;
                end
                if (word == W_IRQ_EN && wb_sel_i[0]) irq_en_reg <= wb_dat_i[1:0];
`ifdef DSP_SLAVE_TIMEOUT_EN
                if (word == W_TIMEOUT_LIMIT)
                    timeout_limit_reg <= merge(timeout_limit_reg, wb_dat_i, wmask);
`endif
            end

            // FSM updates follow the W1C clears so a same-edge set wins.
            case (state_reg)
                ST_IDLE: if (start_wr) state_reg <= ST_RUN;
                ST_RUN: begin
                    if (abort_wr) begin
                        state_reg <= ST_IDLE;
                    end else if (timeout_hit) begin
                        state_reg          <= ST_IDLE;
                        status_timeout_reg <= 1'b1;
                    end else if (done) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    for (int i = 0; i < 5; i++) result_reg[i] <= dsp_out[i];
                    state_reg <= ST_FINISH;
                end
                ST_FINISH: begin
                    status_done_reg <= 1'b1;
                    state_reg       <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase

            irq_reg <= |({status_timeout_reg, status_done_reg} & irq_en_reg);
        end
    end

    assign wb_ack_o       = ack_reg;
    assign wb_dat_o       = dat_reg;
    assign interrupt      = irq_reg;
    assign dsp_input0_reg = {{(dw-4){1'b0}}, (state_reg == ST_RUN) ? eqn_reg : 4'd0};
    assign dsp_input1_reg = input_reg[0];
    assign dsp_input2_reg = input_reg[1];
    assign dsp_input3_reg = input_reg[2];
    assign dsp_input4_reg = input_reg[3];

endmodule

// File: tb/tb_dsp_slave_regs.sv
// Scoreboard bench for dsp_slave_regs: reads queue their expected data, a negedge monitor checks it.
module tb_dsp_slave_regs;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [31:0] dsp_input0_reg, dsp_input1_reg, dsp_input2_reg, dsp_input3_reg, dsp_input4_reg;
    logic [31:0] dsp_output0_reg, dsp_output1_reg, dsp_output2_reg, dsp_output3_reg, dsp_output4_reg;
    logic        done, interrupt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 wb_clk = ~wb_clk;

    dsp_slave_regs dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .dsp_input0_reg(dsp_input0_reg), .dsp_input1_reg(dsp_input1_reg),
        .dsp_input2_reg(dsp_input2_reg), .dsp_input3_reg(dsp_input3_reg),
        .dsp_input4_reg(dsp_input4_reg),
        .dsp_output0_reg(dsp_output0_reg), .dsp_output1_reg(dsp_output1_reg),
        .dsp_output2_reg(dsp_output2_reg), .dsp_output3_reg(dsp_output3_reg),
        .dsp_output4_reg(dsp_output4_reg),
        .done(done), .interrupt(interrupt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read acknowledge pops one expected value.
    always @(negedge wb_clk) begin
        if (wb_ack_o && !wb_we_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ack: got ack with no pending read, data %h", wb_dat_o);
            end else begin
                string nm;
                logic [31:0] ev;
                nm = name_q.pop_front();
                ev = exp_q.pop_front();
                chk(nm, wb_dat_o, ev);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the commit edge.
    task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit seen = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge wb_clk);
            if (wb_ack_o) seen = 1;
        end
        if (!seen) begin
            chk("ack_timeout", {31'd0, wb_ack_o}, 32'd1);
        end else begin
            @(negedge wb_clk);
            chk("ack_single_cycle", {31'd0, wb_ack_o}, 32'd0);
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        $display("xfer we=%0d adr=%h dat=%h sel=%h", we, adr, dat, sel);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        bus(1'b1, adr, dat, sel);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus(1'b0, adr, 32'd0, 4'hF);
    endtask

    task automatic quick_run(input logic [31:0] out0);
        dsp_output0_reg = out0;
        done = 1;
        wr(32'h00, 32'h101);
        @(negedge wb_clk);
        done = 0;
        repeat (3) @(negedge wb_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_n = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
        wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0; done = 0;
        dsp_output0_reg = 0; dsp_output1_reg = 0; dsp_output2_reg = 0;
        dsp_output3_reg = 0; dsp_output4_reg = 0;
        repeat (3) @(negedge wb_clk);
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_irq", {31'd0, interrupt}, 32'd0);
        chk("rst_in0", dsp_input0_reg, 32'd0);
        wb_rst_n = 1;
        @(negedge wb_clk);

        // 1: reset values of the whole map
        for (int a = 0; a <= 32'h2C; a += 4) rd(a, 32'd0, "reset_read");
        chk("idle_irq", {31'd0, interrupt}, 32'd0);

        // 2: basic equation run
        wr(32'h2C, 32'h1);
        wr(32'h04, 32'd5);
        wr(32'h0C, 32'd7);
        wr(32'h00, 32'h1);
        chk("eqn_gated_idle", dsp_input0_reg, 32'd0);
        wr(32'h00, 32'h101);
        chk("eqn_in_run", dsp_input0_reg, 32'd1);
        chk("input1_drive", dsp_input1_reg, 32'd5);
        chk("input3_drive", dsp_input3_reg, 32'd7);
        rd(32'h28, 32'h1, "status_busy");
        rd(32'h00, 32'h1, "ctrl_start_reads0");
        repeat (6) @(negedge wb_clk);
        chk("eqn_still_run", dsp_input0_reg, 32'd1);
        dsp_output0_reg = 32'd12;
        dsp_output2_reg = 32'h33;
        done = 1;
        @(negedge wb_clk);
        chk("eqn_gated_capture", dsp_input0_reg, 32'd0);
        done = 0;
        repeat (3) @(negedge wb_clk);
        chk("irq_after_done", {31'd0, interrupt}, 32'd1);
        rd(32'h14, 32'd12, "result0");
        rd(32'h1C, 32'h33, "result2");
        rd(32'h28, 32'h2, "status_done");

        // 3: W1C and set-wins race
        wr(32'h28, 32'h2);
        chk("irq_lag", {31'd0, interrupt}, 32'd1);
        @(negedge wb_clk);
        chk("irq_dropped", {31'd0, interrupt}, 32'd0);
        rd(32'h28, 32'h0, "status_cleared");
        wr(32'h00, 32'h101);
        done = 1;
        @(negedge wb_clk);
        done = 0;
        wr(32'h28, 32'h2);
        rd(32'h28, 32'h2, "set_wins_clear");
        wr(32'h28, 32'h2);
        rd(32'h28, 32'h0, "status_cleared2");

        // 4: writes while busy, then abort
        dsp_output0_reg = 32'd77;
        wr(32'h00, 32'h101);
        wr(32'h00, 32'h102);
        wr(32'h04, 32'd9);
        rd(32'h00, 32'h1, "busy_eqn_locked");
        rd(32'h04, 32'd5, "busy_input_locked");
        rd(32'h28, 32'h1, "busy_no_restart");
        chk("busy_eqn_drive", dsp_input0_reg, 32'd1);
        wr(32'h00, 32'h200);
        rd(32'h28, 32'h0, "abort_status");
        rd(32'h14, 32'd12, "abort_result_kept");
        chk("abort_eqn_gated", dsp_input0_reg, 32'd0);

        // byte enables, unmapped address
        wr(32'h08, 32'hAABBCCDD);
        wr(32'h08, 32'h11223344, 4'h5);
        rd(32'h08, 32'hAA22CC44, "byte_enable");
        wr(32'h3C, 32'hFFFFFFFF);
        rd(32'h3C, 32'h0, "unmapped");

        // done already high on entry to RUN
        quick_run(32'h55);
        rd(32'h14, 32'h55, "done_on_entry_result");
        rd(32'h28, 32'h2, "done_on_entry_status");
        wr(32'h28, 32'h2);
        @(negedge wb_clk);

        // 5: EQN=0 waits for abort, then optional timeout
        wr(32'h00, 32'h100);
        chk("eqn0_drive", dsp_input0_reg, 32'd0);
        repeat (25) @(negedge wb_clk);
        rd(32'h28, 32'h1, "eqn0_waits");
        wr(32'h00, 32'h200);
        rd(32'h28, 32'h0, "eqn0_abort");
`ifdef DSP_SLAVE_TIMEOUT_EN
        wr(32'h30, 32'd20);
        rd(32'h30, 32'd20, "tlimit_rw");
        wr(32'h00, 32'h100);
        repeat (5) @(negedge wb_clk);
        rd(32'h28, 32'h1, "timeout_pending");
        repeat (25) @(negedge wb_clk);
        rd(32'h28, 32'h4, "timeout_status");
        chk("timeout_irq_masked", {31'd0, interrupt}, 32'd0);
        wr(32'h2C, 32'h3);
        @(negedge wb_clk);
        chk("timeout_irq", {31'd0, interrupt}, 32'd1);
        wr(32'h28, 32'h4);
        rd(32'h28, 32'h0, "timeout_cleared");
        wr(32'h30, 32'd0);
`else
        wr(32'h30, 32'd20);
        rd(32'h30, 32'd0, "tlimit_unmapped");
        rd(32'h28, 32'h0, "no_timeout_status");
`endif

        // 6: asynchronous reset during RUN and mid-ack
        wr(32'h2C, 32'h1);
        quick_run(32'h66);
        chk("pre_reset_irq", {31'd0, interrupt}, 32'd1);
        wr(32'h00, 32'h101);
        chk("pre_reset_run", dsp_input0_reg, 32'd1);
        @(posedge wb_clk); #1;
        wb_rst_n = 0;
        #1;
        chk("arst_irq", {31'd0, interrupt}, 32'd0);
        chk("arst_in0", dsp_input0_reg, 32'd0);
        chk("arst_in1", dsp_input1_reg, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1;
        @(negedge wb_clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h04; wb_sel_i = 4'hF;
        @(posedge wb_clk); #1;
        chk("midack_ack_up", {31'd0, wb_ack_o}, 32'd1);
        wb_rst_n = 0;
        #1;
        chk("midack_ack_cleared", {31'd0, wb_ack_o}, 32'd0);
        chk("midack_dat_cleared", wb_dat_o, 32'd0);
        @(negedge wb_clk);
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge wb_clk);
        wb_rst_n = 1;
        repeat (3) begin
            @(negedge wb_clk);
            chk("no_spurious_ack", {31'd0, wb_ack_o}, 32'd0);
        end
        rd(32'h28, 32'h0, "post_reset_status");
        rd(32'h2C, 32'h0, "post_reset_irq_en");
        rd(32'h14, 32'h0, "post_reset_result0");

        repeat (2) @(negedge wb_clk);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
